mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
Round-robin arbiter that shares one shift-add multiplier (start/busy/valid handshake, 2*WIDTH product) between NUM_REQ requesters.
- Sits between the key-generation and exponentiation clients and the single multiplier instance.
- Captures the winning requester's operands, sequences the multiplier's start pulse, and routes the product back with a per-requester done strobe.
- Only one multiplication is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- WIDTH, 1024, operand width in bits; product is 2*WIDTH

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-high
- req_in  input  NUM_REQ  level request per requester
- op_a_in  input  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- op_b_in  input  NUM_REQ*WIDTH  packed operand B, same packing
- grant_out  output  NUM_REQ  one-hot, one-cycle pulse: operands of that requester captured
- done_out  output  NUM_REQ  one-hot, one-cycle pulse: product_out valid for that requester
- product_out  output  2*WIDTH  last product; held until the next completion
- busy_out  output  1  high whenever state != IDLE
- mult_a_out  output  WIDTH  registered operand A to multiplier
- mult_b_out  output  WIDTH  registered operand B to multiplier
- mult_start_out  output  1  one-cycle start pulse to multiplier
- mult_busy_in  input  1  multiplier busy
- mult_valid_in  input  1  multiplier one-cycle result-valid pulse
- mult_result_in  input  2*WIDTH  multiplier product

Behaviour:
- Clock and reset: one clock clk_in; reset rst_in is synchronous and active-high.
- Reset values: every output is 0, state = IDLE, owner = 0, RR pointer = NUM_REQ-1 (requester 0 has highest priority first).
- Reset mid-operation aborts silently: no done_out is issued. The multiplier is reset by the same rst_in.
- Default every cycle: grant_out, done_out and mult_start_out are driven to 0 unless set below. They are never high for more than one cycle.
- States:
  - IDLE: req_in is sampled. If any bit is set, pick the first set bit searching upward from ptr+1, wrapping modulo NUM_REQ. Then:
    - owner <= winner
    - grant_out <= onehot(winner)
    - mult_a_out/mult_b_out <= that requester's op_a/op_b slices
    - go to ISSUE
    - If no bit is set, stay in IDLE.
  - ISSUE: if mult_busy_in == 0 and mult_valid_in == 0, set mult_start_out <= 1 and go to WAIT. Otherwise stay in ISSUE and retry each cycle.
  - WAIT: on mult_valid_in == 1:
    - product_out <= mult_result_in
    - done_out <= onehot(owner)
    - ptr <= owner
    - go to IDLE
    - mult_busy_in is ignored in WAIT.
- mult_valid_in arriving in IDLE or ISSUE (stale pulse) does not change product_out or done_out.
- Operands are registered at grant time. mult_a_out/mult_b_out stay stable from grant until the next grant, so requesters may change op_*_in any time after grant_out.
- Latency: req sampled in IDLE at cycle t gives:
  - grant_out at t+1
  - mult_start_out at t+2 (multiplier idle)
  - done_out/product_out at the cycle after mult_valid_in
  - Next grant no earlier than the cycle after done_out.
- Request protocol:
  - req_in is a level. Dropping it before grant withdraws the request.
  - A requester wanting one operation drops req_in on seeing grant_out. If still high when the arbiter next reaches IDLE, it counts as a new request.
  - req_in changes outside IDLE are ignored.
- Fairness: with all requesters continuously requesting, grant order is 0,1,...,NUM_REQ-1,0,... Each requester waits at most NUM_REQ-1 operations.
- Simultaneous events: multiple req_in bits in the same cycle resolve by RR order only. No fixed priority beyond the initial pointer.
- A zero operand is passed through unchanged. The arbiter relies on mult_valid_in for completion and applies no timeout.

Test Plan:
Bench uses WIDTH=8, NUM_REQ=4, with the shift-add multiplier block attached.
1. Single request: req_in=0001, op_a0=13, op_b0=11 -> grant_out=0001 one cycle later; one mult_start_out pulse; done_out=0001 with product_out=143; busy_out low after.
2. All requesting, held: req_in=1111, operands (i+2)*(i+3) -> done_out order 0001,0010,0100,1000,0001; products 6,12,20,30.
3. RR pointer: after a grant to requester 2, req_in=0101 in IDLE -> grant 0001 (search starts at 3, wraps to 0), not 0100.
4. Zero/max operands: op_b=0 with op_a=200 -> product_out=0 and done_out still pulses. 255*255 -> product_out=65025.
5. Stale valid: force mult_busy_in=1 in ISSUE for 3 cycles -> mult_start_out delayed until busy drops. A mult_valid_in pulse in IDLE leaves product_out unchanged and done_out=0.
6. Reset mid-WAIT: assert rst_in during multiplication -> next cycle all outputs 0 and state IDLE, no done_out. A fresh req_in=0010 afterwards completes normally.

Source files
------------

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin arbiter in front of a single shift-add multiplier.
//
// One multiplication is in flight at a time. The winning requester's operands
// are captured at grant, the multiplier is started once it is idle, and the
// product is returned with a one-cycle done strobe to the owner.
//
// Ports
//   clk_in, rst_in      clock, synchronous active-high reset
//   req_in              level request per requester
//   op_a_in, op_b_in    packed operands, requester i at [i*WIDTH +: WIDTH]
//   grant_out           one-cycle one-hot pulse: operands of that requester captured
//   done_out            one-cycle one-hot pulse: product_out valid for that requester
//   product_out         last product, held until the next completion
//   busy_out            high whenever the arbiter is not idle
//   mult_a_out/_b_out   registered operands to the multiplier
//   mult_start_out      one-cycle start pulse to the multiplier
//   mult_busy_in        multiplier busy
//   mult_valid_in       multiplier one-cycle result-valid pulse
//   mult_result_in      multiplier product
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | sample req_in, grant the next requester in round-robin order
// ISSUE  | operands captured, waiting for an idle multiplier to start it
// WAIT   | multiplication in flight, waiting for mult_valid_in
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 1024
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_in,
    input  logic [NUM_REQ*WIDTH-1:0] op_a_in,
    input  logic [NUM_REQ*WIDTH-1:0] op_b_in,
    output logic [NUM_REQ-1:0]       grant_out,
    output logic [NUM_REQ-1:0]       done_out,
    output logic [2*WIDTH-1:0]       product_out,
    output logic                     busy_out,
    output logic [WIDTH-1:0]         mult_a_out,
    output logic [WIDTH-1:0]         mult_b_out,
    output logic                     mult_start_out,
    input  logic                     mult_busy_in,
    input  logic                     mult_valid_in,
    input  logic [2*WIDTH-1:0]       mult_result_in
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [PTR_W-1:0]   owner_q,   owner_d;
    logic [PTR_W-1:0]   ptr_q,     ptr_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic [NUM_REQ-1:0] done_q,    done_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   mult_a_q,  mult_a_d;
    logic [WIDTH-1:0]   mult_b_q,  mult_b_d;
    logic               start_q,   start_d;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   cand;

    // Search upward from ptr+1, wrapping; the pointer holds the last owner so
    // the requester just served ends up with the lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_in[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        grant_d   = '0;
        done_d    = '0;
        product_d = product_q;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        start_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d         = winner;
                    grant_d[winner] = 1'b1;
                    mult_a_d        = op_a_in[int'(winner)*WIDTH +: WIDTH];
                    mult_b_d        = op_b_in[int'(winner)*WIDTH +: WIDTH];
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A valid pulse here is stale; hold off so it cannot be
                // mistaken for the result of the operation about to start.
                if (!mult_busy_in && !mult_valid_in) begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mult_valid_in) begin
                    product_d       = mult_result_in;
                    done_d[owner_q] = 1'b1;
                    ptr_d           = owner_q;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            ptr_q     <= PTR_W'(NUM_REQ - 1);
            grant_q   <= '0;
            done_q    <= '0;
            product_q <= '0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            product_q <= product_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
            start_q   <= start_d;
        end
    end

    assign grant_out      = grant_q;
    assign done_out       = done_q;
    assign product_out    = product_q;
    assign busy_out       = (state_q != S_IDLE);
    assign mult_a_out     = mult_a_q;
    assign mult_b_out     = mult_b_q;
    assign mult_start_out = start_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter with a behavioural multiplier attached. A round-robin
// reference model predicts grant order and products per batch of requests;
// a negedge monitor pops the expectations whenever grant/done pulses appear.
module tb_mult_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] opa = '0;
    logic [NR*W-1:0] opb = '0;
    logic [NR-1:0]   grant_out, done_out;
    logic [2*W-1:0]  product_out;
    logic            busy_out;
    logic [W-1:0]    mult_a_out, mult_b_out;
    logic            mult_start_out;
    logic            mult_busy_in, mult_valid_in;
    logic [2*W-1:0]  mult_result_in;

    logic            mul_busy = 1'b0;
    logic            mul_valid = 1'b0;
    logic [2*W-1:0]  mul_res = '0;
    logic [2*W-1:0]  mul_acc = '0;
    int              mul_cnt = 0;
    int              mul_lat = 8;
    logic            force_busy = 1'b0;
    logic            inj_valid = 1'b0;
    logic [2*W-1:0]  inj_res = '0;

    assign mult_busy_in   = mul_busy | force_busy;
    assign mult_valid_in  = mul_valid | inj_valid;
    assign mult_result_in = inj_valid ? inj_res : mul_res;

    mult_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .req_in        (req),
        .op_a_in       (opa),
        .op_b_in       (opb),
        .grant_out     (grant_out),
        .done_out      (done_out),
        .product_out   (product_out),
        .busy_out      (busy_out),
        .mult_a_out    (mult_a_out),
        .mult_b_out    (mult_b_out),
        .mult_start_out(mult_start_out),
        .mult_busy_in  (mult_busy_in),
        .mult_valid_in (mult_valid_in),
        .mult_result_in(mult_result_in)
    );

    // Multiplier stand-in: busy for mul_lat cycles after start, then a valid pulse.
    always @(posedge clk) begin
        if (rst) begin
            mul_busy  <= 1'b0;
            mul_valid <= 1'b0;
            mul_cnt   <= 0;
            mul_res   <= '0;
        end else begin
            mul_valid <= 1'b0;
            if (mult_start_out && !mul_busy) begin
                mul_busy <= 1'b1;
                mul_cnt  <= mul_lat;
                mul_acc  <= 16'(mult_a_out) * 16'(mult_b_out);
            end else if (mul_busy) begin
                if (mul_cnt <= 1) begin
                    mul_busy  <= 1'b0;
                    mul_valid <= 1'b1;
                    mul_res   <= mul_acc;
                end else begin
                    mul_cnt <= mul_cnt - 1;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int             id;
        logic [2*W-1:0] prod;
    } exp_t;

    int             grant_q[$];
    exp_t           exp_q[$];
    int             ptr_m = NR - 1;
    logic [2*W-1:0] last_prod = '0;
    logic [NR-1:0]  first_grant = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    function automatic int rr_pick(input int p, input logic [NR-1:0] m);
        for (int k = 1; k <= NR; k++) begin
            if (m[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    // Every requester in the mask asks once and drops on its grant, so the
    // order is successive round-robin picks from a shrinking pending set.
    function automatic void push_batch(input logic [NR-1:0] mask,
                                       input logic [NR*W-1:0] av,
                                       input logic [NR*W-1:0] bv);
        logic [NR-1:0] pend;
        int            w;
        exp_t          e;
        pend = mask;
        while (pend != '0) begin
            w = rr_pick(ptr_m, pend);
            grant_q.push_back(w);
            e.id   = w;
            e.prod = 16'(int'(av[w*W +: W]) * int'(bv[w*W +: W]));
            exp_q.push_back(e);
            last_prod = e.prod;
            pend[w]   = 1'b0;
            ptr_m     = w;
        end
    endfunction

    logic prev_busy_in = 1'b0;
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        int   g;
        exp_t e;
        if (!rst) begin
            if (grant_out != '0) begin
                if (grant_q.size() == 0) fail_evt("grant_unexpected", 64'(grant_out));
                else begin
                    g = grant_q.pop_front();
                    check("grant", 64'(grant_out), 64'(1 << g));
                end
            end
            if (done_out != '0) begin
                if (exp_q.size() == 0) fail_evt("done_unexpected", 64'(done_out));
                else begin
                    e = exp_q.pop_front();
                    check("done", 64'(done_out), 64'(1 << e.id));
                    check("product", 64'(product_out), 64'(e.prod));
                end
            end
            if (mult_start_out) begin
                check("start_while_busy", 64'(prev_busy_in), 64'd0);
                check("start_width", 64'(prev_start), 64'd0);
            end
        end
        prev_busy_in = mult_busy_in;
        prev_start   = mult_start_out;
    end

    // hold < 0: random busy forcing; hold >= 0: force busy for hold cycles
    // after the first grant and check the grant-to-start distance.
    task automatic run_batch(input logic [NR-1:0] mask, input logic [NR*W-1:0] av,
                             input logic [NR*W-1:0] bv, input int hold);
        int budget, grant_cyc, ngr, c0;
        @(negedge clk);
        opa        = av;
        opb        = bv;
        mul_lat    = $urandom_range(1, 12);
        force_busy = (hold > 0);
        push_batch(mask, av, bv);
        req         = mask;
        c0          = cyc;
        first_grant = '0;
        ngr         = 0;
        grant_cyc   = -1;
        budget      = 0;
        while ((grant_q.size() != 0 || exp_q.size() != 0) && budget < 600) begin
            @(negedge clk);
            budget++;
            if (hold < 0) force_busy = ($urandom_range(0, 3) == 0);
            if (grant_out != '0) begin
                if (first_grant == '0) begin
                    first_grant = grant_out;
                    check("grant_latency", 64'(cyc - c0), 64'd1);
                end
                req = req & ~grant_out;
                for (int i = 0; i < NR; i++) begin
                    if (grant_out[i]) begin
                        opa[i*W +: W] = W'($urandom);
                        opb[i*W +: W] = W'($urandom);
                    end
                end
                grant_cyc = cyc;
                ngr++;
            end
            if (mult_start_out && hold >= 0 && grant_cyc >= 0) begin
                check("issue_delay", 64'(cyc - grant_cyc), 64'((ngr == 1) ? hold + 1 : 1));
                grant_cyc = -1;
            end
            if (hold > 0 && grant_cyc >= 0 && (cyc - grant_cyc) >= hold) force_busy = 1'b0;
        end
        if (budget >= 600) begin
            fail_evt("batch_timeout", 64'(mask));
            grant_q.delete();
            exp_q.delete();
        end
        force_busy = 1'b0;
        req        = '0;
        @(negedge clk);
        check("busy_after", 64'(busy_out), 64'd0);
        check("product_hold", 64'(product_out), 64'(last_prod));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_pulses"}, 64'({grant_out, done_out, mult_start_out, busy_out}), 64'd0);
        check({name, "_product"}, 64'(product_out), 64'd0);
        check({name, "_mult_ops"}, 64'({mult_a_out, mult_b_out}), 64'd0);
    endtask

    initial begin
        logic [NR*W-1:0] av, bv;
        logic [2*W-1:0]  p;
        int              t;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // all four requesting at once: order 0,1,2,3 from the reset pointer
        for (int i = 0; i < NR; i++) begin
            av[i*W +: W] = W'(i + 2);
            bv[i*W +: W] = W'(i + 3);
        end
        run_batch(4'b1111, av, bv, 0);
        check("fair_first", 64'(first_grant), 64'b0001);
        run_batch(4'b0001, av, bv, 0);

        // single request 13*11
        av = '0; bv = '0;
        av[7:0] = 8'd13; bv[7:0] = 8'd11;
        run_batch(4'b0001, av, bv, 0);
        check("single_product", 64'(product_out), 64'd143);

        // pointer after grant to 2: 0101 picks 0 first
        av = {8'd9, 8'd8, 8'd7, 8'd6};
        bv = {8'd5, 8'd4, 8'd3, 8'd2};
        run_batch(4'b0100, av, bv, 0);
        run_batch(4'b0101, av, bv, 0);
        check("rr_wrap", 64'(first_grant), 64'b0001);

        // zero and max operands
        av = '0; bv = '0;
        av[7:0] = 8'd200;
        run_batch(4'b0001, av, bv, 0);
        check("zero_product", 64'(product_out), 64'd0);
        av[7:0] = 8'd255; bv[7:0] = 8'd255;
        run_batch(4'b0001, av, bv, 0);
        check("max_product", 64'(product_out), 64'd65025);

        // busy held 3 cycles in ISSUE delays start
        av[15:8] = 8'd5; bv[15:8] = 8'd6;
        run_batch(4'b0010, av, bv, 3);

        // stale valid in IDLE
        p = product_out;
        @(negedge clk);
        inj_res   = 16'hBEEF;
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        check("stale_product", 64'(product_out), 64'(p));
        check("stale_done", 64'(done_out), 64'd0);

        // reset in the middle of a multiplication
        @(negedge clk);
        av = '0; bv = '0;
        av[15:8] = 8'd7; bv[15:8] = 8'd9;
        opa = av; opb = bv;
        mul_lat = 10;
        push_batch(4'b0010, av, bv);
        req = 4'b0010;
        t = 0;
        while (grant_out == '0 && t < 20) begin @(negedge clk); t++; end
        req = '0;
        while (!mult_start_out && t < 40) begin @(negedge clk); t++; end
        if (t >= 40) fail_evt("reset_setup_timeout", 64'(t));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        grant_q.delete();
        exp_q.delete();
        ptr_m = NR - 1;
        rst = 1'b0;
        repeat (14) @(negedge clk);
        run_batch(4'b0010, av, bv, 0);
        check("post_reset_grant", 64'(first_grant), 64'b0010);
        check("post_reset_product", 64'(product_out), 64'd63);

        // randomized batches
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < NR; i++) begin
                av[i*W +: W] = W'($urandom);
                bv[i*W +: W] = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            end
            run_batch(NR'($urandom_range(1, 15)), av, bv, -1);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
